// File: rtl/mac_wb_stage.sv
// Unsigned multiply-accumulate execution stage: takes one (a, b, c) triple, computes a*b + c
// after a fixed latency and returns the double-width result as two write-data words, low first.
module mac_wb_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  arst_ni,
    input  logic [DATA_W-1:0]     operand_a_i,
    input  logic [DATA_W-1:0]     operand_b_i,
    input  logic [2*DATA_W-1:0]   operand_c_i,
    input  logic                  operation_valid_i,
    output logic                  operation_ready_o,
    output logic [DATA_W-1:0]     wr_data_o,
    output logic                  wr_data_valid_o,
    input  logic                  wr_data_ready_i,
    output logic                  overflow_o,
    output logic                  drop_o,
    output logic [15:0]           result_count_o
);

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [2*DATA_W-1:0] w_data_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        SEND_LO = 2'd2,
        SEND_HI = 2'd3
    } state_e;

    localparam int unsigned      CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e         state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    data_t          a_r, a_nxt_s;
    data_t          b_r, b_nxt_s;
    w_data_t        c_r, c_nxt_s;
    w_data_t        res_r, res_nxt_s;
    logic           ovf_r, ovf_nxt_s;
    logic [15:0]    count_r, count_nxt_s;
    logic           drop_r, drop_nxt_s;

    logic           op_ready_r, op_ready_nxt_s;
    logic           wr_valid_r, wr_valid_nxt_s;
    data_t          wr_data_r, wr_data_nxt_s;
    logic           ovf_out_r, ovf_out_nxt_s;

    w_data_t        prod_s;
    logic [2*DATA_W:0] sum_s;

    // Full-width product plus addend, keeping the carry out of 2*DATA_W bits.
    assign prod_s = {{DATA_W{1'b0}}, a_r} * {{DATA_W{1'b0}}, b_r};
    assign sum_s  = {1'b0, prod_s} + {1'b0, c_r};

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        c_nxt_s     = c_r;
        res_nxt_s   = res_r;
        ovf_nxt_s   = ovf_r;
        count_nxt_s = count_r;

        case (state_r)
            IDLE: begin
                if (operation_valid_i) begin
                    a_nxt_s     = operand_a_i;
                    b_nxt_s     = operand_b_i;
                    c_nxt_s     = operand_c_i;
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    res_nxt_s   = sum_s[2*DATA_W-1:0];
                    ovf_nxt_s   = sum_s[2*DATA_W];
                    state_nxt_s = SEND_LO;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            SEND_LO: begin
                if (wr_data_ready_i) begin
                    state_nxt_s = SEND_HI;
                end else begin
                    state_nxt_s = SEND_LO;
                end
            end
            SEND_HI: begin
                if (wr_data_ready_i) begin
                    count_nxt_s = count_r + 16'd1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND_HI;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // A triple offered while not ready is discarded and remembered until reset.
        if (operation_valid_i && !op_ready_r) begin
            drop_nxt_s = 1'b1;
        end else begin
            drop_nxt_s = drop_r;
        end

        // Outputs are decoded from the next state so they can be registered.
        op_ready_nxt_s = 1'b0;
        wr_valid_nxt_s = 1'b0;
        wr_data_nxt_s  = {DATA_W{1'b0}};
        ovf_out_nxt_s  = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                op_ready_nxt_s = 1'b1;
            end
            CALC: begin
                op_ready_nxt_s = 1'b0;
            end
            SEND_LO: begin
                wr_valid_nxt_s = 1'b1;
                wr_data_nxt_s  = res_nxt_s[DATA_W-1:0];
            end
            SEND_HI: begin
                wr_valid_nxt_s = 1'b1;
                wr_data_nxt_s  = res_nxt_s[2*DATA_W-1:DATA_W];
                ovf_out_nxt_s  = ovf_nxt_s;
            end
            default: begin
                op_ready_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            a_r        <= {DATA_W{1'b0}};
            b_r        <= {DATA_W{1'b0}};
            c_r        <= {(2*DATA_W){1'b0}};
            res_r      <= {(2*DATA_W){1'b0}};
            ovf_r      <= 1'b0;
            count_r    <= 16'd0;
            drop_r     <= 1'b0;
            op_ready_r <= 1'b1;
            wr_valid_r <= 1'b0;
            wr_data_r  <= {DATA_W{1'b0}};
            ovf_out_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            a_r        <= a_nxt_s;
            b_r        <= b_nxt_s;
            c_r        <= c_nxt_s;
            res_r      <= res_nxt_s;
            ovf_r      <= ovf_nxt_s;
            count_r    <= count_nxt_s;
            drop_r     <= drop_nxt_s;
            op_ready_r <= op_ready_nxt_s;
            wr_valid_r <= wr_valid_nxt_s;
            wr_data_r  <= wr_data_nxt_s;
            ovf_out_r  <= ovf_out_nxt_s;
        end
    end

    assign operation_ready_o = op_ready_r;
    assign wr_data_valid_o   = wr_valid_r;
    assign wr_data_o         = wr_data_r;
    assign overflow_o        = ovf_out_r;
    assign drop_o            = drop_r;
    assign result_count_o    = count_r;

endmodule

// File: tb/tb_mac_wb_stage.sv
// Self-checking bench for mac_wb_stage: directed scenarios plus randomized operations checked
// against an arithmetic reference model.
module tb_mac_wb_stage;

    localparam int DW  = 32;
    localparam int LAT = 2;

    logic            clk;
    logic            arst_ni;
    logic [DW-1:0]   operand_a;
    logic [DW-1:0]   operand_b;
    logic [2*DW-1:0] operand_c;
    logic            op_valid;
    logic            op_ready;
    logic [DW-1:0]   wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic            overflow;
    logic            drop;
    logic [15:0]     result_count;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_count;
    logic        exp_drop;

    typedef struct {
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic          ovf_lo;
        logic          ovf_hi;
        int            lo_cyc;
        int            hi_cyc;
        int            lo_hold;
        bit            lo_unstable;
        bit            calc_bad;
        bit            timeout;
        logic          ready_after;
        logic          valid_after;
        logic [15:0]   count_after;
        logic          drop_after;
    } obs_t;

    mac_wb_stage #(.DATA_W(DW), .MUL_LAT(LAT)) dut (
        .clk               (clk),
        .arst_ni           (arst_ni),
        .operand_a_i       (operand_a),
        .operand_b_i       (operand_b),
        .operand_c_i       (operand_c),
        .operation_valid_i (op_valid),
        .operation_ready_o (op_ready),
        .wr_data_o         (wr_data),
        .wr_data_valid_o   (wr_valid),
        .wr_data_ready_i   (wr_ready),
        .overflow_o        (overflow),
        .drop_o            (drop),
        .result_count_o    (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact unsigned a*b + c with one extra bit for the carry.
    function automatic logic [2*DW:0] mac_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2*DW-1:0] c);
        logic [2*DW:0] aa, bb, cc;
        aa = {{(DW+1){1'b0}}, a};
        bb = {{(DW+1){1'b0}}, b};
        cc = {1'b0, c};
        return aa * bb + cc;
    endfunction

    // Drives one triple and records what the DUT produced (no judgement here).
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2*DW-1:0] c, input int lo_stall, input int drop_at,
                          output obs_t o);
        int cyc;
        int phase;
        bit done;
        o.lo = '0; o.hi = '0; o.ovf_lo = 1'b0; o.ovf_hi = 1'b0;
        o.lo_cyc = -1; o.hi_cyc = -1; o.lo_hold = 0; o.lo_unstable = 1'b0;
        o.calc_bad = 1'b0; o.timeout = 1'b0;
        @(negedge clk);
        operand_a = a; operand_b = b; operand_c = c;
        op_valid = 1'b1; wr_ready = 1'b0;
        @(negedge clk);
        cyc = 0; phase = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            if (wr_valid) begin
                if (phase == 0) begin
                    if (o.lo_hold == 0) begin
                        o.lo = wr_data; o.lo_cyc = cyc; o.ovf_lo = overflow;
                    end else if (wr_data !== o.lo || overflow !== 1'b0) begin
                        o.lo_unstable = 1'b1;
                    end
                    o.lo_hold++;
                    if (o.lo_hold > lo_stall) wr_ready = 1'b1;
                    if (wr_ready) phase = 1;
                end else begin
                    o.hi = wr_data; o.hi_cyc = cyc; o.ovf_hi = overflow;
                    done = 1'b1;
                end
            end else if (op_ready !== 1'b0 || wr_data !== '0 || overflow !== 1'b0) begin
                o.calc_bad = 1'b1;
            end
            op_valid  = (cyc == drop_at);
            operand_a = (cyc == drop_at) ? 32'd9 : $urandom;
            operand_b = $urandom;
            operand_c = {$urandom, $urandom};
            @(negedge clk);
            cyc++;
        end
        o.timeout     = !done;
        o.ready_after = op_ready;
        o.valid_after = wr_valid;
        o.count_after = result_count;
        o.drop_after  = drop;
        op_valid = 1'b0;
        wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        arst_ni = 1'b0;
        op_valid = 1'b0; wr_ready = 1'b0;
        operand_a = '0; operand_b = '0; operand_c = '0;
        #12;
        n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", op_ready); end
        n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", wr_valid); end
        n_tests++; if (wr_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", wr_data); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b want 0", drop); end
        n_tests++; if (result_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %h want 0", result_count); end
        @(negedge clk);
        arst_ni = 1'b1;
        exp_count = 16'd0;
        exp_drop  = 1'b0;
    endtask

    task automatic test_basic();
        obs_t o;
        logic [2*DW:0] r;
        r = mac_ref(32'd3, 32'd5, 64'd7);
        run_op(32'd3, 32'd5, 64'd7, 0, -1, o);
        exp_count = exp_count + 16'd1;
        n_tests++; if (o.timeout) begin n_fail++; $display("FAIL basic_timeout: no result within bound"); end
        n_tests++; if (o.lo !== r[DW-1:0]) begin n_fail++; $display("FAIL basic_lo: got %h want %h", o.lo, r[DW-1:0]); end
        n_tests++; if (o.hi !== r[2*DW-1:DW]) begin n_fail++; $display("FAIL basic_hi: got %h want %h", o.hi, r[2*DW-1:DW]); end
        n_tests++; if (o.ovf_hi !== r[2*DW] || o.ovf_lo !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b/%b want 0/%b", o.ovf_lo, o.ovf_hi, r[2*DW]); end
        n_tests++; if (o.lo_cyc != LAT) begin n_fail++; $display("FAIL basic_lo_cycle: got %0d want %0d", o.lo_cyc, LAT); end
        n_tests++; if (o.hi_cyc != LAT + 1) begin n_fail++; $display("FAIL basic_hi_cycle: got %0d want %0d", o.hi_cyc, LAT + 1); end
        n_tests++; if (o.calc_bad) begin n_fail++; $display("FAIL basic_calc_outputs: got nonzero outputs while busy, want idle outputs"); end
        n_tests++; if (o.ready_after !== 1'b1 || o.valid_after !== 1'b0) begin n_fail++; $display("FAIL basic_after: got ready %b valid %b want 1 0", o.ready_after, o.valid_after); end
        n_tests++; if (o.count_after !== exp_count) begin n_fail++; $display("FAIL basic_count: got %h want %h", o.count_after, exp_count); end
    endtask

    task automatic test_overflow();
        obs_t o;
        logic [2*DW:0] r;
        r = mac_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, o);
        exp_count = exp_count + 16'd1;
        n_tests++; if (o.lo !== r[DW-1:0]) begin n_fail++; $display("FAIL ovf_lo: got %h want %h", o.lo, r[DW-1:0]); end
        n_tests++; if (o.hi !== r[2*DW-1:DW]) begin n_fail++; $display("FAIL ovf_hi: got %h want %h", o.hi, r[2*DW-1:DW]); end
        n_tests++; if (o.ovf_hi !== 1'b1 || o.ovf_lo !== 1'b0) begin n_fail++; $display("FAIL ovf_flag: got lo %b hi %b want 0 1", o.ovf_lo, o.ovf_hi); end
        n_tests++; if (o.count_after !== exp_count) begin n_fail++; $display("FAIL ovf_count: got %h want %h", o.count_after, exp_count); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [2*DW:0] r;
        r = mac_ref(32'd3, 32'd5, 64'd7);
        run_op(32'd3, 32'd5, 64'd7, 5, -1, o);
        exp_count = exp_count + 16'd1;
        n_tests++; if (o.lo !== r[DW-1:0] || o.hi !== r[2*DW-1:DW]) begin n_fail++; $display("FAIL bp_words: got %h %h want %h %h", o.lo, o.hi, r[DW-1:0], r[2*DW-1:DW]); end
        n_tests++; if (o.lo_hold != 6) begin n_fail++; $display("FAIL bp_hold: got %0d cycles want 6", o.lo_hold); end
        n_tests++; if (o.lo_unstable) begin n_fail++; $display("FAIL bp_stable: got changing low word want stable %h", r[DW-1:0]); end
        n_tests++; if (o.hi_cyc != LAT + 6) begin n_fail++; $display("FAIL bp_hi_cycle: got %0d want %0d", o.hi_cyc, LAT + 6); end
        n_tests++; if (o.count_after !== exp_count) begin n_fail++; $display("FAIL bp_count: got %h want %h", o.count_after, exp_count); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]   ta [4];
        logic [DW-1:0]   tb [4];
        logic [2*DW-1:0] tc [4];
        logic [2*DW:0]   exp_q [$];
        logic [2*DW:0]   e;
        int              hs [$];
        logic [DW-1:0]   lo_w;
        int cyc, accepted, got, half;
        for (int i = 0; i < 4; i++) begin
            ta[i] = $urandom; tb[i] = $urandom; tc[i] = {$urandom, $urandom};
        end
        wr_ready = 1'b1; accepted = 0; got = 0; half = 0; cyc = 0; lo_w = '0;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            if (wr_valid) begin
                if (half == 0) begin
                    lo_w = wr_data; half = 1;
                end else begin
                    half = 0; got++; hs.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++; $display("FAIL b2b_extra: got unexpected result %h%h", wr_data, lo_w);
                    end else begin
                        e = exp_q.pop_front();
                        n_tests++; if ({wr_data, lo_w} !== e[2*DW-1:0] || overflow !== e[2*DW]) begin n_fail++; $display("FAIL b2b_result%0d: got %b %h%h want %b %h", got, overflow, wr_data, lo_w, e[2*DW], e[2*DW-1:0]); end
                    end
                end
            end
            if (op_ready && accepted < 4) begin
                operand_a = ta[accepted]; operand_b = tb[accepted]; operand_c = tc[accepted];
                op_valid = 1'b1;
                exp_q.push_back(mac_ref(ta[accepted], tb[accepted], tc[accepted]));
                accepted++;
            end else begin
                op_valid = 1'b0;
            end
            cyc++;
        end
        op_valid = 1'b0;
        @(negedge clk);
        wr_ready = 1'b0;
        exp_count = exp_count + 16'd4;
        n_tests++; if (got != 4) begin n_fail++; $display("FAIL b2b_results: got %0d results want 4", got); end
        for (int i = 1; i < hs.size(); i++) begin
            n_tests++; if (hs[i] - hs[i-1] != LAT + 3) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", i, hs[i] - hs[i-1], LAT + 3); end
        end
        n_tests++; if (result_count !== exp_count) begin n_fail++; $display("FAIL b2b_count: got %h want %h", result_count, exp_count); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b want 0", drop); end
    endtask

    task automatic test_drop();
        obs_t o;
        logic [2*DW:0] r;
        r = mac_ref(32'd3, 32'd5, 64'd7);
        run_op(32'd3, 32'd5, 64'd7, 0, 1, o);
        exp_count = exp_count + 16'd1;
        exp_drop  = 1'b1;
        n_tests++; if (o.lo !== r[DW-1:0] || o.hi !== r[2*DW-1:DW]) begin n_fail++; $display("FAIL drop_result: got %h %h want %h %h", o.lo, o.hi, r[DW-1:0], r[2*DW-1:DW]); end
        n_tests++; if (o.drop_after !== exp_drop) begin n_fail++; $display("FAIL drop_flag: got %b want %b", o.drop_after, exp_drop); end
        n_tests++; if (o.count_after !== exp_count) begin n_fail++; $display("FAIL drop_count: got %h want %h", o.count_after, exp_count); end
        repeat (3) @(negedge clk);
        n_tests++; if (wr_valid !== 1'b0 || result_count !== exp_count) begin n_fail++; $display("FAIL drop_single: got valid %b count %h want 0 %h", wr_valid, result_count, exp_count); end
        n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b want 1", drop); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge clk);
        operand_a = 32'h11; operand_b = 32'h22; operand_c = 64'd5;
        op_valid = 1'b1; wr_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        wr_ready = 1'b0;
        n_tests++; if (wr_valid !== 1'b1 || wr_data !== 32'h0) begin n_fail++; $display("FAIL mid_in_hi: got valid %b data %h want 1 0", wr_valid, wr_data); end
        #2 arst_ni = 1'b0;
        #1;
        n_tests++; if (wr_valid !== 1'b0 || wr_data !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_outputs: got valid %b data %h ovf %b want 0 0 0", wr_valid, wr_data, overflow); end
        n_tests++; if (op_ready !== 1'b1 || drop !== 1'b0 || result_count !== 16'd0) begin n_fail++; $display("FAIL mid_status: got ready %b drop %b count %h want 1 0 0", op_ready, drop, result_count); end
        repeat (2) @(negedge clk);
        arst_ni = 1'b1;
        exp_count = 16'd0;
        exp_drop  = 1'b0;
        run_op(32'd2, 32'd2, 64'd0, 0, -1, o);
        exp_count = exp_count + 16'd1;
        n_tests++; if (o.lo !== 32'h4 || o.hi !== 32'h0 || o.ovf_hi !== 1'b0) begin n_fail++; $display("FAIL mid_after: got %h %h %b want 4 0 0", o.lo, o.hi, o.ovf_hi); end
        n_tests++; if (o.count_after !== exp_count || o.drop_after !== exp_drop) begin n_fail++; $display("FAIL mid_after_status: got count %h drop %b want %h %b", o.count_after, o.drop_after, exp_count, exp_drop); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2*DW:0]   r;
        logic [DW-1:0]   a, b;
        logic [2*DW-1:0] c;
        int stall, drop_at;
        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            c = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            stall   = $urandom_range(0, 3);
            drop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, LAT) : -1;
            r = mac_ref(a, b, c);
            run_op(a, b, c, stall, drop_at, o);
            exp_count = exp_count + 16'd1;
            if (drop_at >= 0) exp_drop = 1'b1;
            n_tests++; if (o.lo !== r[DW-1:0] || o.hi !== r[2*DW-1:DW] || o.ovf_hi !== r[2*DW]) begin n_fail++; $display("FAIL rand%0d_result: got %b %h%h want %b %h", i, o.ovf_hi, o.hi, o.lo, r[2*DW], r[2*DW-1:0]); end
            n_tests++; if (o.lo_cyc != LAT || o.hi_cyc != LAT + 1 + stall || o.lo_unstable || o.calc_bad) begin n_fail++; $display("FAIL rand%0d_timing: got lo@%0d hi@%0d unstable %b busy_out %b want lo@%0d hi@%0d", i, o.lo_cyc, o.hi_cyc, o.lo_unstable, o.calc_bad, LAT, LAT + 1 + stall); end
            n_tests++; if (o.count_after !== exp_count || o.drop_after !== exp_drop) begin n_fail++; $display("FAIL rand%0d_status: got count %h drop %b want %h %b", i, o.count_after, o.drop_after, exp_count, exp_drop); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
